// File: rtl/pwmr_access_sched.sv
// pwmr_access_sched
//   Access scheduler for the parallel-write / multi-read PE buffer FIFO.
//   Arbitrates RD_NUM reader pop requests against a single push source. It makes at most one
//   transfer per cycle, so it never pushes and pops together. A shadow occupancy per reader
//   ensures that a pop is only granted when that reader's data is already in the FIFO.
//   All FIFO-facing controls are registered and last exactly one cycle.
// Build option:
//   PWMR_SCHED_PERF_EN -- adds the perf_pop_cnt / perf_push_cnt / perf_stall_cnt outputs.
//                         Scheduling behaviour is identical with or without it.

module pwmr_access_sched #(
   parameter int RD_NUM     = 4,
   parameter int WR_NUM     = 1,
   parameter int ADDR_WIDTH = 4,
   parameter int RAM_DEPTH  = 16,
   parameter int WR_STARVE  = 4
) (
   input  logic                             clk,
   input  logic                             Reset,
   input  logic                             enable,
   input  logic                             flush,
   input  logic [RD_NUM-1:0]                rd_req,
   input  logic [ADDR_WIDTH*RD_NUM-1:0]     rd_offset,
   output logic [RD_NUM-1:0]                rd_gnt,
   input  logic                             src_valid,
   output logic                             src_ready,
   output logic                             fifo_push,
   output logic [RD_NUM-1:0]                fifo_pop,
   output logic [ADDR_WIDTH-1:0]            fifo_pop_offset,
   output logic                             fifo_reset,
   output logic [(ADDR_WIDTH+1)*RD_NUM-1:0] occ
`ifdef PWMR_SCHED_PERF_EN
   ,
   output logic [31:0]                      perf_pop_cnt,
   output logic [31:0]                      perf_push_cnt,
   output logic [31:0]                      perf_stall_cnt
`endif
);

   localparam int OCC_W = ADDR_WIDTH + 1;
   localparam int PTR_W = (RD_NUM > 1) ? $clog2(RD_NUM) : 1;
   localparam int STV_W = (WR_STARVE > 0) ? $clog2(WR_STARVE + 1) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [OCC_W-1:0] WR_INC     = OCC_W'(WR_NUM);
   localparam logic [31:0]      WR_NUM_U   = 32'(WR_NUM);
   localparam logic [31:0]      DEPTH_U    = 32'(RAM_DEPTH);
   localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(WR_STARVE);
   localparam logic [PTR_W-1:0] LAST_RD    = PTR_W'(RD_NUM - 1);

   // Reader index k positions after the round-robin pointer, wrapping over RD_NUM.
   function automatic logic [PTR_W-1:0] rr_plus(input logic [PTR_W-1:0] base, input int k);
      return PTR_W'((int'(base) + k) % RD_NUM);
   endfunction

   // State and shadow bookkeeping
   logic [1:0]            state_q, state_d;
   logic [OCC_W-1:0]      occ_q [RD_NUM];
   logic [OCC_W-1:0]      occ_d [RD_NUM];
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [STV_W-1:0]      starve_q, starve_d;

   // Registered one-cycle outputs
   logic [RD_NUM-1:0]     gnt_q, gnt_d;
   logic                  ready_q, ready_d;
   logic [ADDR_WIDTH-1:0] pop_off_q, pop_off_d;
   logic                  fifo_reset_q, fifo_reset_d;
   logic                  rst_seen_q;

   // Decision signals
   logic [ADDR_WIDTH-1:0] off_s [RD_NUM];
   logic [RD_NUM-1:0]     rd_elig_s;
   logic                  wr_room_s;
   logic                  wr_elig_s;
   logic                  any_rd_s;
   logic [PTR_W-1:0]      cand_s;
   logic [PTR_W-1:0]      win_idx_s;
   logic                  decide_s;
   logic                  push_s;
   logic                  pop_s;

   // Per-reader offsets and eligibility, plus write eligibility (room in every reader's view).
   always_comb begin
      rd_elig_s = '0;
      wr_room_s = 1'b1;
      for (int i = 0; i < RD_NUM; i++) begin
         off_s[i]     = rd_offset[i*ADDR_WIDTH +: ADDR_WIDTH];
         rd_elig_s[i] = rd_req[i] && (off_s[i] != '0) &&
                        (occ_q[i] >= {1'b0, off_s[i]}) && !gnt_q[i];
         wr_room_s    = wr_room_s && ((32'(occ_q[i]) + WR_NUM_U) <= DEPTH_U);
      end
      wr_elig_s = src_valid && !ready_q && wr_room_s;
   end

   // Round-robin winner search and the push-vs-pop decision for this edge.
   always_comb begin
      win_idx_s = '0;
      cand_s    = '0;
      // Scan from the far end so that the candidate closest to rr_ptr is written last and wins.
      for (int k = RD_NUM - 1; k >= 0; k--) begin
         cand_s    = rr_plus(rr_ptr_q, k);
         win_idx_s = rd_elig_s[cand_s] ? cand_s : win_idx_s;
      end
      any_rd_s = |rd_elig_s;
      decide_s = (state_q == ST_RUN) && enable && !flush;
      // A starved write beats readers; otherwise the write only fills idle cycles.
      push_s   = decide_s && wr_elig_s && ((starve_q >= STARVE_LIM) || !any_rd_s);
      pop_s    = decide_s && any_rd_s && !push_s;
   end

   // Next-state logic: FSM, shadow occupancy, round-robin pointer, starvation count, outputs.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      starve_d     = starve_q;
      gnt_d        = '0;
      ready_d      = 1'b0;
      pop_off_d    = '0;
      fifo_reset_d = 1'b0;
      for (int i = 0; i < RD_NUM; i++) begin
         occ_d[i] = occ_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            state_d = enable ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            if (flush) begin
               state_d      = ST_FLUSH;
               fifo_reset_d = 1'b1;
               rr_ptr_d     = '0;
               starve_d     = '0;
               for (int i = 0; i < RD_NUM; i++) begin
                  occ_d[i] = '0;
               end
            end else if (!enable) begin
               state_d = ST_IDLE;
            end else if (push_s) begin
               ready_d  = 1'b1;
               starve_d = '0;
               for (int i = 0; i < RD_NUM; i++) begin
                  occ_d[i] = occ_q[i] + WR_INC;
               end
            end else if (pop_s) begin
               gnt_d[win_idx_s]  = 1'b1;
               pop_off_d         = off_s[win_idx_s];
               occ_d[win_idx_s]  = occ_q[win_idx_s] - {1'b0, off_s[win_idx_s]};
               rr_ptr_d          = (win_idx_s == LAST_RD) ? '0 : (win_idx_s + PTR_W'(1));
               // The write lost this cycle although it could have gone.
               if (wr_elig_s && (starve_q < STARVE_LIM)) begin
                  starve_d = starve_q + STV_W'(1);
               end else begin
                  starve_d = starve_q;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            state_d  = enable ? ST_RUN : ST_IDLE;
            rr_ptr_d = '0;
            starve_d = '0;
            for (int i = 0; i < RD_NUM; i++) begin
               occ_d[i] = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; the first cycle after Reset also pulses fifo_reset to realign the FIFO.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         starve_q     <= '0;
         gnt_q        <= '0;
         ready_q      <= 1'b0;
         pop_off_q    <= '0;
         fifo_reset_q <= 1'b0;
         rst_seen_q   <= 1'b1;
         for (int i = 0; i < RD_NUM; i++) begin
            occ_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         starve_q     <= starve_d;
         gnt_q        <= gnt_d;
         ready_q      <= ready_d;
         pop_off_q    <= pop_off_d;
         fifo_reset_q <= fifo_reset_d | rst_seen_q;
         rst_seen_q   <= 1'b0;
         for (int i = 0; i < RD_NUM; i++) begin
            occ_q[i] <= occ_d[i];
         end
      end
   end

   // Pack the shadow occupancy onto the flat output bus.
   always_comb begin
      occ = '0;
      for (int i = 0; i < RD_NUM; i++) begin
         occ[i*OCC_W +: OCC_W] = occ_q[i];
      end
   end

   assign rd_gnt          = gnt_q;
   assign fifo_pop        = gnt_q;
   assign src_ready       = ready_q;
   assign fifo_push       = ready_q;
   assign fifo_pop_offset = pop_off_q;
   assign fifo_reset      = fifo_reset_q;

`ifdef PWMR_SCHED_PERF_EN
   logic [31:0] perf_pop_q, perf_push_q, perf_stall_q;
   logic        perf_clr_s;
   logic        stall_s;

   // Counter clear on flush entry/FLUSH state, and stall condition (requests pending, none grantable).
   always_comb begin
      perf_clr_s = ((state_q == ST_RUN) && flush) || (state_q == ST_FLUSH);
      stall_s    = (state_q == ST_RUN) && !flush && (|rd_req) && !any_rd_s;
   end

   // Wrapping event counters for grants, pushes and reader stalls.
   always_ff @(posedge clk) begin
      if (Reset) begin
         perf_pop_q   <= 32'd0;
         perf_push_q  <= 32'd0;
         perf_stall_q <= 32'd0;
      end else if (perf_clr_s) begin
         perf_pop_q   <= 32'd0;
         perf_push_q  <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_pop_q   <= perf_pop_q + (pop_s ? 32'd1 : 32'd0);
         perf_push_q  <= perf_push_q + (push_s ? 32'd1 : 32'd0);
         perf_stall_q <= perf_stall_q + (stall_s ? 32'd1 : 32'd0);
      end
   end

   assign perf_pop_cnt   = perf_pop_q;
   assign perf_push_cnt  = perf_push_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_pwmr_access_sched.sv
// tb_pwmr_access_sched -- directed bench for pwmr_access_sched with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_pwmr_access_sched;

   localparam int RD_NUM = 4;
   localparam int AW     = 4;
   localparam int OW     = AW + 1;

   logic                 clk = 1'b0;
   logic                 Reset;
   logic                 enable;
   logic                 flush;
   logic [RD_NUM-1:0]    rd_req;
   logic [AW*RD_NUM-1:0] rd_offset;
   logic [RD_NUM-1:0]    rd_gnt;
   logic                 src_valid;
   logic                 src_ready;
   logic                 fifo_push;
   logic [RD_NUM-1:0]    fifo_pop;
   logic [AW-1:0]        fifo_pop_offset;
   logic                 fifo_reset;
   logic [OW*RD_NUM-1:0] occ;
`ifdef PWMR_SCHED_PERF_EN
   logic [31:0]          perf_pop_cnt, perf_push_cnt, perf_stall_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int viol   = 0;

   always #5 clk = ~clk;

   pwmr_access_sched #(
      .RD_NUM(4), .WR_NUM(1), .ADDR_WIDTH(4), .RAM_DEPTH(16), .WR_STARVE(4)
   ) dut (
      .clk(clk), .Reset(Reset), .enable(enable), .flush(flush),
      .rd_req(rd_req), .rd_offset(rd_offset), .rd_gnt(rd_gnt),
      .src_valid(src_valid), .src_ready(src_ready),
      .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_pop_offset(fifo_pop_offset),
      .fifo_reset(fifo_reset), .occ(occ)
`ifdef PWMR_SCHED_PERF_EN
      , .perf_pop_cnt(perf_pop_cnt), .perf_push_cnt(perf_push_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   // Count and report one comparison.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [OW-1:0] occ_at(input int i);
      return occ[i*OW +: OW];
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   // Hold src_valid until n pushes are acknowledged (bounded), then drop it.
   task automatic push_n(input int n, input int budget, input string tag);
      int cnt;
      cnt = 0;
      src_valid = 1'b1;
      for (int c = 0; c < budget && cnt < n; c++) begin
         cyc();
         if (src_ready) cnt++;
      end
      src_valid = 1'b0;
      check_eq(tag, cnt, n);
   endtask

   // Push and pop must never coincide; the FIFO-side copies must match the handshakes.
   always @(negedge clk) begin
      if ((fifo_push && (|fifo_pop)) || (fifo_push !== src_ready) || (fifo_pop !== rd_gnt))
         viol++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushes, pops, gseen, g_acc;
      logic [3:0] exp_g [5];
      logic       exp_r [5];

      Reset = 1'b1; enable = 1'b0; flush = 1'b0; rd_req = 4'b0000;
      rd_offset = 16'h0000; src_valid = 1'b0;
      repeat (3) cyc();
      check_eq("rst_gnt", rd_gnt, 4'b0000);
      check_eq("rst_ready", src_ready, 1'b0);
      check_eq("rst_freset", fifo_reset, 1'b0);
      check_eq("rst_occ", occ, 20'h00000);
      check_eq("rst_popoff", fifo_pop_offset, 4'h0);
      Reset = 1'b0;
      cyc();
      check_eq("realign_pulse", fifo_reset, 1'b1);
      enable = 1'b1;
      cyc();
      check_eq("realign_end", fifo_reset, 1'b0);

      // 1: fill to depth; pushes alternate with the acknowledge cycle, 17th is blocked
      pushes = 0; pops = 0;
      src_valid = 1'b1;
      for (int c = 0; c < 60; c++) begin
         cyc();
         if (src_ready) pushes++;
         if (fifo_push) pops++;
      end
      src_valid = 1'b0;
      check_eq("s1_ready_pulses", pushes, 16);
      check_eq("s1_push_pulses", pops, 16);
      for (int i = 0; i < RD_NUM; i++) check_eq("s1_occ16", occ_at(i), 5'd16);

      // flush down to empty, then refill to 8
      flush = 1'b1;
      cyc();
      check_eq("flush_pulse", fifo_reset, 1'b1);
      check_eq("flush_occ", occ, 20'h00000);
      flush = 1'b0;
      cyc();
      check_eq("flush_end", fifo_reset, 1'b0);
      push_n(8, 40, "fill8");

      // 2: all readers request 2 words; round-robin from reader 0 on consecutive cycles
      rd_offset = {4'd2, 4'd2, 4'd2, 4'd2};
      rd_req = 4'b1111;
      for (int k = 0; k < RD_NUM; k++) begin
         cyc();
         check_eq("s2_gnt", rd_gnt, 4'b0001 << k);
         check_eq("s2_popoff", fifo_pop_offset, 4'd2);
         rd_req[k] = 1'b0;
      end
      for (int i = 0; i < RD_NUM; i++) check_eq("s2_occ6", occ_at(i), 5'd6);
`ifdef PWMR_SCHED_PERF_EN
      check_eq("perf_pop", perf_pop_cnt, 32'd4);
      check_eq("perf_push", perf_push_cnt, 32'd8);
`endif

      // 3: bring reader 0 to occ=1, request 3 -> waits until two pushes land
      rd_offset = {4'd1, 4'd1, 4'd1, 4'd5};
      rd_req = 4'b0001;
      cyc();
      check_eq("s3_pre_gnt", rd_gnt, 4'b0001);
      rd_req = 4'b0000;
      check_eq("s3_occ1", occ_at(0), 5'd1);
      rd_offset = {4'd1, 4'd1, 4'd1, 4'd3};
      rd_req = 4'b0001;
      g_acc = 0;
      for (int c = 0; c < 3; c++) begin
         cyc();
         g_acc = g_acc | int'(rd_gnt);
      end
      check_eq("s3_nogrant", g_acc, 0);
      pushes = 0; gseen = 0;
      src_valid = 1'b1;
      for (int c = 0; c < 20 && gseen == 0; c++) begin
         cyc();
         if (src_ready) begin
            pushes++;
            if (pushes == 2) src_valid = 1'b0;
         end
         if (rd_gnt != 4'b0000) begin
            gseen = int'(rd_gnt);
            check_eq("s3_popoff", fifo_pop_offset, 4'd3);
         end
      end
      src_valid = 1'b0;
      rd_req = 4'b0000;
      check_eq("s3_pushes", pushes, 2);
      check_eq("s3_gnt", gseen, 1);
      check_eq("s3_occ0", occ_at(0), 5'd0);
      check_eq("s3_occ1", occ_at(1), 5'd8);

      // 4: readers 1..3 stay eligible, write waits 4 pops then is forced through
      rd_offset = {4'd1, 4'd1, 4'd1, 4'd1};
      rd_req = 4'b1110;
      src_valid = 1'b1;
      exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0000};
      exp_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         cyc();
         check_eq("s4_gnt", rd_gnt, exp_g[k]);
         check_eq("s4_ready", src_ready, exp_r[k]);
      end
      rd_req = 4'b0000;
      src_valid = 1'b0;
      check_eq("s4_occ0", occ_at(0), 5'd1);
      check_eq("s4_occ1", occ_at(1), 5'd7);
      check_eq("s4_occ3", occ_at(3), 5'd8);

      // 5: flush at occ=9 resets shadow state and the round-robin pointer
      push_n(1, 10, "s5_push1");
      check_eq("s5_occ9", occ_at(3), 5'd9);
      flush = 1'b1;
      cyc();
      check_eq("s5_freset", fifo_reset, 1'b1);
      check_eq("s5_occ0", occ, 20'h00000);
      flush = 1'b0;
      cyc();
      check_eq("s5_freset_end", fifo_reset, 1'b0);
      push_n(2, 20, "s5_push2");
      rd_req = 4'b1111;
      cyc();
      check_eq("s5_first_gnt", rd_gnt, 4'b0001);
      rd_req = 4'b0000;

      // 6: Reset during a grant cycle
      rd_req = 4'b0010;
      cyc();
      check_eq("s6_gnt", rd_gnt, 4'b0010);
      Reset = 1'b1;
      rd_req = 4'b0000;
      cyc();
      check_eq("s6_gnt0", rd_gnt, 4'b0000);
      check_eq("s6_popoff0", fifo_pop_offset, 4'h0);
      check_eq("s6_occ0", occ, 20'h00000);
      check_eq("s6_ready0", src_ready, 1'b0);
      Reset = 1'b0;
      cyc();
      check_eq("s6_realign", fifo_reset, 1'b1);
      cyc();
      check_eq("s6_realign_end", fifo_reset, 1'b0);

      // 7: enable low holds IDLE, keeps occ, grants resume after re-enable
      push_n(3, 20, "s7_push3");
      enable = 1'b0;
      rd_req = 4'b0001;
      g_acc = 0;
      for (int c = 0; c < 3; c++) begin
         cyc();
         g_acc = g_acc | int'(rd_gnt);
      end
      check_eq("s7_idle_nogrant", g_acc, 0);
      check_eq("s7_occ_kept", occ_at(0), 5'd3);
      enable = 1'b1;
      cyc();
      check_eq("s7_wake_gnt0", rd_gnt, 4'b0000);
      cyc();
      check_eq("s7_gnt", rd_gnt, 4'b0001);
      rd_req = 4'b0000;
      check_eq("s7_occ2", occ_at(0), 5'd2);

      cyc();
      check_eq("excl_push_pop", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
